// File: rtl/cpu_regs_pkg.sv
// rtl/cpu_regs_pkg.sv - register select and stack-op encodings for cpu_reg_bank
package cpu_regs_pkg;

    localparam logic [2:0] REG_ACC  = 3'd0;
    localparam logic [2:0] REG_X    = 3'd1;
    localparam logic [2:0] REG_Y    = 3'd2;
    localparam logic [2:0] REG_SP   = 3'd3;
    localparam logic [2:0] REG_PCL  = 3'd4;
    localparam logic [2:0] REG_PCH  = 3'd5;
    localparam logic [2:0] REG_PSR  = 3'd6;
    localparam logic [2:0] REG_NONE = 3'd7;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10,
        SP_NOP  = 2'b11
    } sp_op_t;

endpackage

// File: rtl/cpu_pc_counter.sv
// rtl/cpu_pc_counter.sv - 2*DW program counter: load > byte write > increment
module cpu_pc_counter #(
    parameter int              DW       = 8,
    parameter logic [2*DW-1:0] PC_RESET = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_load,
    input  logic [2*DW-1:0] i_load_val,
    input  logic            i_wr_lo,
    input  logic            i_wr_hi,
    input  logic [DW-1:0]   i_wr_data,
    input  logic            i_inc,
    output logic [2*DW-1:0] o_pc
);

    logic [2*DW-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= PC_RESET;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_wr_lo) begin
            r_pc[DW-1:0] <= i_wr_data;
        end else if (i_wr_hi) begin
            r_pc[2*DW-1:DW] <= i_wr_data;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_reg_bank.sv
// rtl/cpu_reg_bank.sv - 6502-style register bank; REGBANK_BYPASS_EN enables write-through reads
module cpu_reg_bank
    import cpu_regs_pkg::*;
#(
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   SP_RESET  = 8'hFF,
    parameter logic [DW-1:0]   PSR_RESET = 8'h20,
    parameter logic [2*DW-1:0] PC_RESET  = 16'h0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wr_en,
    input  logic [2:0]      i_wr_sel,
    input  logic [DW-1:0]   i_wr_data,
    input  logic [2:0]      i_rd_sel_a,
    input  logic [2:0]      i_rd_sel_b,
    output logic [DW-1:0]   o_rd_data_a,
    output logic [DW-1:0]   o_rd_data_b,
    input  logic            i_pc_inc,
    input  logic            i_pc_load,
    input  logic [2*DW-1:0] i_pc_load_val,
    input  logic [1:0]      i_sp_op,
    input  logic            i_flag_we,
    input  logic [DW-1:0]   i_flag_mask,
    input  logic [DW-1:0]   i_flag_val,
    output logic [DW-1:0]   o_acc,
    output logic [DW-1:0]   o_x,
    output logic [DW-1:0]   o_y,
    output logic [DW-1:0]   o_sp,
    output logic [DW-1:0]   o_psr,
    output logic [2*DW-1:0] o_pc,
    output logic            o_sp_wrap
);

    logic [DW-1:0]   r_acc, r_x, r_y, r_sp, r_psr;
    logic            r_sp_wrap;
    logic [2*DW-1:0] w_pc;
    logic            w_wr_sp, w_wr_psr;

    assign w_wr_sp  = i_wr_en && (i_wr_sel == REG_SP);
    assign w_wr_psr = i_wr_en && (i_wr_sel == REG_PSR);

    cpu_pc_counter #(.DW(DW), .PC_RESET(PC_RESET)) u_pc (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (i_pc_load),
        .i_load_val (i_pc_load_val),
        .i_wr_lo    (i_wr_en && (i_wr_sel == REG_PCL)),
        .i_wr_hi    (i_wr_en && (i_wr_sel == REG_PCH)),
        .i_wr_data  (i_wr_data),
        .i_inc      (i_pc_inc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (i_wr_en) begin
            if (i_wr_sel == REG_ACC) r_acc <= i_wr_data;
            if (i_wr_sel == REG_X)   r_x   <= i_wr_data;
            if (i_wr_sel == REG_Y)   r_y   <= i_wr_data;
        end
    end

    // Wrap flag only reflects stack arithmetic; a direct SP write clears it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sp      <= SP_RESET;
            r_sp_wrap <= 1'b0;
        end else if (w_wr_sp) begin
            r_sp      <= i_wr_data;
            r_sp_wrap <= 1'b0;
        end else if (i_sp_op == SP_PUSH) begin
            r_sp      <= r_sp - 1'b1;
            r_sp_wrap <= (r_sp == '0);
        end else if (i_sp_op == SP_POP) begin
            r_sp      <= r_sp + 1'b1;
            r_sp_wrap <= (r_sp == {DW{1'b1}});
        end else begin
            r_sp_wrap <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_psr <= PSR_RESET;
        end else if (w_wr_psr) begin
            r_psr <= i_wr_data;
        end else if (i_flag_we) begin
            r_psr <= (r_psr & ~i_flag_mask) | (i_flag_val & i_flag_mask);
        end
    end

    function automatic logic [DW-1:0] read_mux(input logic [2:0] sel);
        case (sel)
            REG_ACC: read_mux = r_acc;
            REG_X:   read_mux = r_x;
            REG_Y:   read_mux = r_y;
            REG_SP:  read_mux = r_sp;
            REG_PCL: read_mux = w_pc[DW-1:0];
            REG_PCH: read_mux = w_pc[2*DW-1:DW];
            REG_PSR: read_mux = r_psr;
            default: read_mux = '0;
        endcase
    endfunction

`ifdef REGBANK_BYPASS_EN
    assign o_rd_data_a = (i_wr_en && i_wr_sel == i_rd_sel_a && i_rd_sel_a != REG_NONE)
                         ? i_wr_data : read_mux(i_rd_sel_a);
    assign o_rd_data_b = (i_wr_en && i_wr_sel == i_rd_sel_b && i_rd_sel_b != REG_NONE)
                         ? i_wr_data : read_mux(i_rd_sel_b);
`else
    assign o_rd_data_a = read_mux(i_rd_sel_a);
    assign o_rd_data_b = read_mux(i_rd_sel_b);
`endif

    assign o_acc     = r_acc;
    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_sp      = r_sp;
    assign o_psr     = r_psr;
    assign o_pc      = w_pc;
    assign o_sp_wrap = r_sp_wrap;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// tb/tb_cpu_reg_bank.sv - directed self-checking bench for cpu_reg_bank
module tb_cpu_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [2:0]  rd_sel_a, rd_sel_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic        pc_inc, pc_load;
    logic [15:0] pc_load_val;
    logic [1:0]  sp_op;
    logic        flag_we;
    logic [7:0]  flag_mask, flag_val;
    logic [7:0]  acc, x, y, sp, psr;
    logic [15:0] pc;
    logic        sp_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_reg_bank dut (
        .i_clk(clk), .i_reset(reset),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
        .i_rd_sel_a(rd_sel_a), .i_rd_sel_b(rd_sel_b),
        .o_rd_data_a(rd_data_a), .o_rd_data_b(rd_data_b),
        .i_pc_inc(pc_inc), .i_pc_load(pc_load), .i_pc_load_val(pc_load_val),
        .i_sp_op(sp_op), .i_flag_we(flag_we), .i_flag_mask(flag_mask), .i_flag_val(flag_val),
        .o_acc(acc), .o_x(x), .o_y(y), .o_sp(sp), .o_psr(psr), .o_pc(pc),
        .o_sp_wrap(sp_wrap)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_sel = 3'd7; wr_data = 0;
        pc_inc = 0; pc_load = 0; pc_load_val = 0;
        sp_op = 2'b00; flag_we = 0; flag_mask = 0; flag_val = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic write(input logic [2:0] sel, input logic [7:0] d);
        wr_en = 1; wr_sel = sel; wr_data = d;
        step();
    endtask

    logic [7:0] wvals [7];
    logic [7:0] rexp  [8];

    initial begin
        wvals = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd60, 8'd70, 8'd50};
        rexp  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd60, 8'd70, 8'd50, 8'd0};
        idle();
        rd_sel_a = 0; rd_sel_b = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc, 8'h00);
        check("rst_sp", sp, 8'hFF);
        check("rst_psr", psr, 8'h20);
        check("rst_pc", pc, 16'h0000);
        check("rst_wrap", sp_wrap, 1'b0);
        reset = 0;

        // mid-stream async reset
        write(3'd0, 8'h5A);
        pc_inc = 1; step();
        check("pre_rst_acc", acc, 8'h5A);
        check("pre_rst_pc", pc, 16'h0001);
        #1 reset = 1;
        #1;
        check("async_acc", acc, 8'h00);
        check("async_sp", sp, 8'hFF);
        check("async_psr", psr, 8'h20);
        check("async_pc", pc, 16'h0000);
        @(negedge clk);
        reset = 0;
        step();

        // byte writes
        for (int i = 0; i < 7; i++) write(i[2:0], wvals[i]);
        check("bw_acc", acc, 8'd10);
        check("bw_x", x, 8'd20);
        check("bw_y", y, 8'd30);
        check("bw_sp", sp, 8'd40);
        check("bw_pc", pc, 16'h463C);
        check("bw_psr", psr, 8'd50);
        for (int i = 0; i < 8; i++) begin
            rd_sel_a = i[2:0]; rd_sel_b = 3'(7 - i);
            #1;
            check($sformatf("rd_a%0d", i), rd_data_a, rexp[i]);
            check($sformatf("rd_b%0d", 7 - i), rd_data_b, rexp[7 - i]);
        end

        // PC
        pc_load = 1; pc_load_val = 16'hFFFF; step();
        check("pc_load_ffff", pc, 16'hFFFF);
        pc_inc = 1; step();
        check("pc_wrap", pc, 16'h0000);
        pc_inc = 1; wr_en = 1; wr_sel = 3'd4; wr_data = 8'h12; step();
        check("pc_wrl_noinc", pc, 16'h0012);
        pc_inc = 1; pc_load = 1; pc_load_val = 16'hC000; step();
        check("pc_load_over_inc", pc, 16'hC000);
        pc_inc = 1; step();
        check("pc_inc", pc, 16'hC001);

        // SP
        write(3'd3, 8'h00);
        check("sp_wr0", sp, 8'h00);
        check("sp_wr0_wrap", sp_wrap, 1'b0);
        sp_op = 2'b01; step();
        check("push_wrap_sp", sp, 8'hFF);
        check("push_wrap_flag", sp_wrap, 1'b1);
        step();
        check("wrap_pulse_end", sp_wrap, 1'b0);
        sp_op = 2'b10; step();
        check("pop_wrap_sp", sp, 8'h00);
        check("pop_wrap_flag", sp_wrap, 1'b1);
        sp_op = 2'b01; wr_en = 1; wr_sel = 3'd3; wr_data = 8'h80; step();
        check("sp_wr_over_push", sp, 8'h80);
        check("sp_wr_no_wrap", sp_wrap, 1'b0);
        sp_op = 2'b01; step();
        check("push_plain", sp, 8'h7F);
        check("push_plain_wrap", sp_wrap, 1'b0);
        sp_op = 2'b11; step();
        check("sp_nop", sp, 8'h7F);

        // flags
        write(3'd6, 8'h20);
        flag_we = 1; flag_mask = 8'h83; flag_val = 8'h81; step();
        check("flag_masked", psr, 8'hA1);
        flag_we = 1; flag_mask = 8'hFF; flag_val = 8'hFF;
        wr_en = 1; wr_sel = 3'd6; wr_data = 8'h00; step();
        check("psr_wr_over_flag", psr, 8'h00);

        // simultaneous updates on independent registers
        wr_en = 1; wr_sel = 3'd0; wr_data = 8'h33;
        pc_inc = 1; sp_op = 2'b10; flag_we = 1; flag_mask = 8'h01; flag_val = 8'h01;
        step();
        check("sim_acc", acc, 8'h33);
        check("sim_pc", pc, 16'hC002);
        check("sim_sp", sp, 8'h80);
        check("sim_psr", psr, 8'h01);

        // write-through read
        wr_en = 1; wr_sel = 3'd0; wr_data = 8'hDE; rd_sel_a = 3'd0; rd_sel_b = 3'd1;
        #1;
`ifdef REGBANK_BYPASS_EN
        check("bypass_a", rd_data_a, 8'hDE);
`else
        check("bypass_a", rd_data_a, 8'h33);
`endif
        check("bypass_b_other", rd_data_b, 8'd20);
        step();
        check("bypass_acc_after", acc, 8'hDE);
        wr_en = 1; wr_sel = 3'd7; wr_data = 8'hAB; rd_sel_a = 3'd7;
        #1;
        check("rd_none", rd_data_a, 8'h00);
        step();
        check("wr_none_acc", acc, 8'hDE);
        check("wr_none_x", x, 8'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
